// File: rtl/pulse_train_tx.sv
// Burst generator whose every high/low level lasts exactly HOLD_COUNT+1 cycles.
// Optional stop-after-current-pulse input enabled by PULSE_TRAIN_TX_ABORT_EN.
module pulse_train_tx #(
  parameter int HOLD_COUNT  = 31,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [COUNT_WIDTH-1:0] count_i,
`ifdef PULSE_TRAIN_TX_ABORT_EN
  input  logic                   abort_i,
`endif
  output logic                   ready_o,
  output logic                   signal_o,
  output logic                   done_o,
  output logic [COUNT_WIDTH-1:0] remaining_o
);

  localparam int P  = HOLD_COUNT + 1;
  localparam int PW = $clog2(P) + 1;
  localparam logic [PW-1:0] PhaseLast = PW'(P - 1);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                   signal_q, signal_d;
  logic                   done_q, done_d;
  logic                   lastPhase;
  logic                   stopNow;
`ifdef PULSE_TRAIN_TX_ABORT_EN
  logic                   stop_q, stop_d;
`endif

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    signal_d    = signal_q;
    done_d      = 1'b0;
    lastPhase   = (phase_q == PhaseLast);
`ifdef PULSE_TRAIN_TX_ABORT_EN
    stop_d  = stop_q;
    stopNow = stop_q | abort_i;
`else
    stopNow = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        phase_d  = '0;
        signal_d = 1'b0;
`ifdef PULSE_TRAIN_TX_ABORT_EN
        stop_d = 1'b0;
`endif
        if (start_i) begin
          if (count_i != '0) begin
            state_d     = HIGH;
            remaining_d = count_i;
            signal_d    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      HIGH: begin
`ifdef PULSE_TRAIN_TX_ABORT_EN
        stop_d = stopNow;
`endif
        if (lastPhase) begin
          state_d  = LOW;
          phase_d  = '0;
          signal_d = 1'b0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      LOW: begin
`ifdef PULSE_TRAIN_TX_ABORT_EN
        stop_d = stopNow;
`endif
        if (lastPhase) begin
          phase_d = '0;
          // A stop request only takes effect once the full low phase is done.
          if ((remaining_q > COUNT_WIDTH'(1)) && !stopNow) begin
            remaining_d = remaining_q - COUNT_WIDTH'(1);
            state_d     = HIGH;
            signal_d    = 1'b1;
          end else begin
            remaining_d = '0;
            state_d     = IDLE;
            done_d      = 1'b1;
`ifdef PULSE_TRAIN_TX_ABORT_EN
            stop_d = 1'b0;
`endif
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        phase_d     = '0;
        remaining_d = '0;
        signal_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      remaining_q <= '0;
      signal_q    <= 1'b0;
      done_q      <= 1'b0;
`ifdef PULSE_TRAIN_TX_ABORT_EN
      stop_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      signal_q    <= signal_d;
      done_q      <= done_d;
`ifdef PULSE_TRAIN_TX_ABORT_EN
      stop_q      <= stop_d;
`endif
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign signal_o    = signal_q;
  assign done_o      = done_q;
  assign remaining_o = remaining_q;

endmodule

// File: tb/tb_pulse_train_tx.sv
// Directed bench for pulse_train_tx with HOLD_COUNT=3 (P=4); abort case under PULSE_TRAIN_TX_ABORT_EN.
module tb_pulse_train_tx;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic [7:0] count_i;
`ifdef PULSE_TRAIN_TX_ABORT_EN
  logic       abort_i;
`endif
  logic       ready_o;
  logic       signal_o;
  logic       done_o;
  logic [7:0] remaining_o;

  int total = 0;
  int bad   = 0;

  pulse_train_tx #(.HOLD_COUNT(3), .COUNT_WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .count_i     (count_i),
`ifdef PULSE_TRAIN_TX_ABORT_EN
    .abort_i     (abort_i),
`endif
    .ready_o     (ready_o),
    .signal_o    (signal_o),
    .done_o      (done_o),
    .remaining_o (remaining_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    stepCycle();
    checkOutput({tag, ".ready"},  32'(ready_o),     32'd1);
    checkOutput({tag, ".done"},   32'(done_o),      32'd0);
    checkOutput({tag, ".signal"}, 32'(signal_o),    32'd0);
    checkOutput({tag, ".remain"}, 32'(remaining_o), 32'd0);
  endtask

  // Issue start with count c and check every cycle up to the done cycle.
  // extraAt>0 drives a second start (count 7) during that cycle, which must be dropped.
  task automatic applyStimulus(input string tag, input int c, input int extraAt);
    int last;
    start_i = 1'b1;
    count_i = 8'(c);
    stepCycle();
    start_i = 1'b0;
    last = 2 * P * c + 1;
    for (int k = 1; k <= last; k++) begin
      logic expSig, expReady, expDone;
      int   expRem;
      expReady = (k > 2 * P * c);
      expDone  = (k == last);
      expSig   = !expReady && (((k - 1) % (2 * P)) < P);
      expRem   = expReady ? 0 : c - ((k - 1) / (2 * P));
      checkOutput($sformatf("%s.signal@%0d", tag, k), 32'(signal_o),    32'(expSig));
      checkOutput($sformatf("%s.ready@%0d",  tag, k), 32'(ready_o),     32'(expReady));
      checkOutput($sformatf("%s.done@%0d",   tag, k), 32'(done_o),      32'(expDone));
      checkOutput($sformatf("%s.remain@%0d", tag, k), 32'(remaining_o), 32'(expRem));
      if (k == extraAt) begin
        start_i = 1'b1;
        count_i = 8'd7;
      end else begin
        start_i = 1'b0;
      end
      if (k < last) stepCycle();
    end
  endtask

  initial begin
    reset   = 1'b1;
    start_i = 1'b0;
    count_i = '0;
`ifdef PULSE_TRAIN_TX_ABORT_EN
    abort_i = 1'b0;
`endif
    stepCycle();
    stepCycle();
    checkOutput("rst.ready",  32'(ready_o),     32'd1);
    checkOutput("rst.signal", 32'(signal_o),    32'd0);
    checkOutput("rst.done",   32'(done_o),      32'd0);
    checkOutput("rst.remain", 32'(remaining_o), 32'd0);
    reset = 1'b0;
    checkIdle("postrst");

    applyStimulus("one", 1, 0);
    checkIdle("one.after");

    applyStimulus("three", 3, 0);
    checkIdle("three.after");

    applyStimulus("zero", 0, 0);
    checkIdle("zero.after");

    // Dropped start in cycle 5, then a back-to-back start issued in the done cycle.
    applyStimulus("two", 2, 5);
    applyStimulus("chain", 1, 0);
    checkIdle("chain.after");

    // Reset sampled at the end of cycle 2 of a five-pulse train.
    start_i = 1'b1;
    count_i = 8'd5;
    stepCycle();
    start_i = 1'b0;
    checkOutput("midrst.sig1", 32'(signal_o), 32'd1);
    stepCycle();
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("midrst.signal", 32'(signal_o),    32'd0);
    checkOutput("midrst.ready",  32'(ready_o),     32'd1);
    checkOutput("midrst.remain", 32'(remaining_o), 32'd0);
    checkOutput("midrst.done",   32'(done_o),      32'd0);
    applyStimulus("afterrst", 2, 0);
    checkIdle("afterrst.after");

`ifdef PULSE_TRAIN_TX_ABORT_EN
    start_i = 1'b1;
    count_i = 8'd4;
    stepCycle();
    start_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      checkOutput($sformatf("abort.signal@%0d", k), 32'(signal_o), 32'(k <= 4));
      checkOutput($sformatf("abort.done@%0d",   k), 32'(done_o),   32'(k == 9));
      checkOutput($sformatf("abort.ready@%0d",  k), 32'(ready_o),  32'(k >= 9));
      checkOutput($sformatf("abort.remain@%0d", k), 32'(remaining_o), (k >= 9) ? 32'd0 : 32'd4);
      abort_i = (k == 6);
      stepCycle();
    end
    abort_i = 1'b0;
    applyStimulus("postabort", 1, 0);
    checkIdle("postabort.after");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_train_tx.md
# pulse_train_tx

Transmit-side counterpart to the team's debounced input path. It drives a single-bit line with a burst of square pulses in which every high and low level is held for a guaranteed minimum time, so a debouncing receiver configured with the same `HOLD_COUNT` reports exactly one rising and one falling event per pulse. It sits on board-facing outputs and on loopback self-test paths. It takes a start/count command and reports completion with a one-cycle `done`.

## Interface
Parameters:
- `HOLD_COUNT`, default 31 — receiver stability window.
  - Each level is held for P = `HOLD_COUNT`+1 cycles.
- `COUNT_WIDTH`, default 8 — width of the pulse-count command.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  command strobe
  - Accepted only on an edge where `ready`=1; ignored otherwise.
- `count`  in  `COUNT_WIDTH`  number of pulses
  - Sampled with an accepted `start`.
- `ready`  out  1  idle; the next `start` will be accepted.
- `signal`  out  1  transmitted line, registered.
- `done`  out  1  one-cycle completion strobe.
- `remaining`  out  `COUNT_WIDTH`  pulses not yet completed.
  - Includes the pulse currently in progress.
- `abort`  in  1  stop after the current pulse.
  - Present only with `PULSE_TRAIN_TX_ABORT_EN`.

## Operation
- States:
  - IDLE
  - HIGH: `signal`=1
  - LOW: `signal`=0
- Phase counter width is $clog2(P)+1. It counts 0..P-1 within HIGH and LOW.
- IDLE + accepted `start`, `count`=C:
  - C>0: go to HIGH. Load `remaining`=C and phase=0.
  - C=0: stay in IDLE. Assert `done` for one cycle; `signal` never rises.
- HIGH, phase=P-1: go to LOW with phase=0.
- LOW, phase=P-1, `remaining`>1: decrement `remaining` and go to HIGH.
- LOW, phase=P-1, `remaining`=1: set `remaining`=0, go to IDLE and assert `done`.
- `ready` is 1 exactly when the state is IDLE.
- Back-to-back trains are legal:
  - `start` is sampled in the same cycle `done`=1.
  - The new HIGH begins immediately after the previous LOW has lasted its full P cycles.
- `count` wraps at 2^`COUNT_WIDTH`; there is no saturation.
- `start` while `ready`=0 is dropped: no effect and no queuing.
- Reset, including mid-train:
  - Next cycle: `signal`=0, `ready`=1, `done`=0, `remaining`=0.
  - State IDLE, phase=0.
  - A truncated pulse is allowed only on reset.

## Timing
- Let E0 be the edge that accepts `start` with C>0, and "cycle k" the cycle after edge E(k-1).
- Every high and every low run of `signal` is exactly P cycles, never shorter.
- Pulse j (1..C):
  - high in cycles 2P(j-1)+1 .. 2P(j-1)+P
  - low in cycles 2P(j-1)+P+1 .. 2Pj
- `ready`=0 in cycles 1..2PC.
- `done`=1 and `ready`=1 in cycle 2PC+1.
- C=0: `done`=1 and `ready`=1 in cycle 1.
- Latency from `start` to the first `signal` rise is 1 cycle, the register output.
- `remaining` behaviour:
  - Equals C from cycle 1.
  - Decrements in the first cycle of each new HIGH.
  - Reaches 0 in the `done` cycle.

## Configuration
- `PULSE_TRAIN_TX_ABORT_EN` defined:
  - Adds the `abort` input port.
  - `abort`=1 in any HIGH or LOW cycle latches a stop request.
  - The current pulse completes its full high and low phases.
  - The block then goes to IDLE with `done`=1 and `remaining`=0, regardless of pulses left.
  - `abort` in IDLE is ignored, as is `abort` coincident with `start`.
  - Reset clears the stop request.
- `PULSE_TRAIN_TX_ABORT_EN` undefined:
  - No `abort` port and no stop-request register.
  - Trains always run to completion or reset.

## Test plan
All scenarios use `HOLD_COUNT`=3, so P=4.
- `start`, `count`=1 -> `signal` high cycles 1-4, low 5-8; `done`=1 and `ready`=1 in cycle 9 only; `remaining` 1 then 0 at cycle 9.
- `start`, `count`=3 -> highs at cycles 1-4, 9-12, 17-20; `remaining` 3/2/1 changing at cycles 9 and 17; `done` at cycle 25.
- `start`, `count`=0 -> `done`=1 in cycle 1; `signal` stays 0; `ready` never drops.
- `start`, `count`=2, plus extra `start` in cycle 5 with `count`=7 -> extra `start` ignored; `done` at cycle 17; exactly 2 pulses; new `start` in cycle 17 gives a high from cycle 18.
- `reset` asserted in cycle 2 of a `count`=5 train -> cycle 3: `signal`=0, `ready`=1, `remaining`=0, no `done`; a subsequent `start` behaves normally.
- (`PULSE_TRAIN_TX_ABORT_EN`) `count`=4, `abort` in cycle 6 -> pulse 1 completes; `done` at cycle 9; no high after cycle 4.
